cdc_hs_arbiter: RTL and testbench



---
 rtl/cdc_hs_arbiter.sv | 129 ++++++++++++
 tb/tb_cdc_hs_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_hs_arbiter.sv
// cdc_hs_arbiter
//   Round-robin arbiter that feeds one 4-phase CDC handshake channel from
//   N_REQ source-side requesters. Each accepted word is tagged with the
//   requester ID as {id, payload}. The block also counts captured words and
//   raises a sticky stall flag.
//
// Ports
//   i_clk      source-domain clock (same clock as the synchronizer)
//   i_rst      synchronous, active-high reset
//   req_valid  per-requester word valid
//   req_data   requester k occupies [k*DATA_W +: DATA_W]
//   req_mask   1 = requester k is eligible for grant
//   req_ready  one-hot accept pulse, combinational, only in IDLE
//   cdc_valid  synchronizer i_valid
//   cdc_data   synchronizer i_data, {id, payload}
//   cdc_busy   synchronizer busy
//   o_grant_id ID of the last accepted requester
//   o_xfer_cnt words captured by the synchronizer (wraps)
//   o_timeout  sticky: the handshake waited more than TIMEOUT cycles
module cdc_hs_arbiter #(
  parameter  int N_REQ   = 4,
  parameter  int DATA_W  = 8,
  parameter  int TIMEOUT = 1023,
  parameter  int CNT_W   = 16,
  localparam int ID_W    = $clog2(N_REQ)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*DATA_W-1:0]  req_data,
  input  logic [N_REQ-1:0]         req_mask,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     cdc_valid,
  output logic [ID_W+DATA_W-1:0]   cdc_data,
  input  logic                     cdc_busy,
  output logic [ID_W-1:0]          o_grant_id,
  output logic [CNT_W-1:0]         o_xfer_cnt,
  output logic                     o_timeout
);

  localparam int WAIT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_HI, WAIT_LO} state_t;

  state_t                          state;
  logic   [ID_W-1:0]               rr_base;   // first index searched
  logic   [ID_W+DATA_W-1:0]        hold;
  logic   [WAIT_W-1:0]             wait_cnt;
  logic   [N_REQ-1:0][DATA_W-1:0]  req_word;
  logic   [N_REQ-1:0]              elig;
  logic   [ID_W-1:0]               grant_idx;
  logic                            grant_ok;
  logic                            do_grant;
  int                              idx_i;

  for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
    assign req_word[k] = req_data[k*DATA_W +: DATA_W];
  end

  assign elig = req_valid & req_mask;

  // First eligible requester at or after rr_base, wrapping modulo N_REQ.
  always_comb begin
    grant_ok  = 1'b0;
    grant_idx = '0;
    idx_i     = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx_i = int'(rr_base) + i;
      if (idx_i >= N_REQ) idx_i = idx_i - N_REQ;
      if (!grant_ok && elig[ID_W'(idx_i)]) begin
        grant_ok  = 1'b1;
        grant_idx = ID_W'(idx_i);
      end
    end
  end

  // Gated by i_rst so a reset cycle never hands out an accept that the
  // reset would then throw away.
  assign do_grant = (state == IDLE) && !i_rst && !cdc_busy && grant_ok;

  always_comb begin
    req_ready = '0;
    if (do_grant) req_ready[grant_idx] = 1'b1;
  end

  assign cdc_valid = (state == SEND);
  assign cdc_data  = hold;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      rr_base    <= '0;
      hold       <= '0;
      wait_cnt   <= '0;
      o_grant_id <= '0;
      o_xfer_cnt <= '0;
      o_timeout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (do_grant) begin
            hold       <= {grant_idx, req_word[grant_idx]};
            o_grant_id <= grant_idx;
            rr_base    <= (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
            state      <= SEND;
          end
        end
        SEND: begin
          // Synchronizer captures on any cycle it is not busy.
          if (!cdc_busy) begin
            o_xfer_cnt <= o_xfer_cnt + 1'b1;
            wait_cnt   <= '0;
            state      <= WAIT_HI;
          end
        end
        WAIT_HI, WAIT_LO: begin
          // Saturating wait counter; the flag is set one wait cycle after
          // saturation and never aborts the handshake.
          if (wait_cnt == WAIT_W'(TIMEOUT)) o_timeout <= 1'b1;
          else                              wait_cnt  <= wait_cnt + 1'b1;
          if (state == WAIT_HI && cdc_busy)       state <= WAIT_LO;
          else if (state == WAIT_LO && !cdc_busy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cdc_hs_arbiter.sv
module tb_cdc_hs_arbiter;
  localparam int N = 4, DW = 8, IW = 2, TO = 1023, CW = 4;

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b1;
  logic [N-1:0]      req_valid = '0;
  logic [N*DW-1:0]   req_data  = '0;
  logic [N-1:0]      req_mask  = '1;
  logic [N-1:0]      req_ready;
  logic              cdc_valid;
  logic [IW+DW-1:0]  cdc_data;
  logic              cdc_busy;
  logic [IW-1:0]     o_grant_id;
  logic [CW-1:0]     o_xfer_cnt;
  logic              o_timeout;

  cdc_hs_arbiter #(.N_REQ(N), .DATA_W(DW), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .req_valid(req_valid), .req_data(req_data),
    .req_mask(req_mask), .req_ready(req_ready), .cdc_valid(cdc_valid),
    .cdc_data(cdc_data), .cdc_busy(cdc_busy), .o_grant_id(o_grant_id),
    .o_xfer_cnt(o_xfer_cnt), .o_timeout(o_timeout)
  );

  always #5 i_clk = ~i_clk;

  // Synchronizer stand-in: busy rises after a capture, falls D cycles later.
  int   dly = 6;
  bit   force_busy = 1'b0;
  logic sbusy = 1'b0;
  int   scnt = 0;
  assign cdc_busy = sbusy | force_busy;
  always @(posedge i_clk) begin
    if (scnt > 1) scnt <= scnt - 1;
    else if (scnt == 1) begin scnt <= 0; sbusy <= 1'b0; end
    else if (cdc_valid && !cdc_busy) begin sbusy <= 1'b1; scnt <= dly; end
  end

  int checks = 0, fails = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int oh2i(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Reference model: transaction phase 0 idle, 1 word offered, 2 waiting
  // for busy high, 3 waiting for busy low.
  int               m_phase = 0, m_last = N - 1, m_gid = 0, m_cnt = 0, m_wait = 0;
  bit               m_to = 1'b0;
  logic [IW+DW-1:0] m_hold = '0;
  bit               chk_en = 1'b0;
  int               glog[$];
  logic [N-1:0]     acc = '0;
  logic [N-1:0]     t_elig, t_rdy;
  int               t_g;

  always @(negedge i_clk) if (chk_en) begin
    t_elig = req_valid & req_mask;
    t_rdy  = '0;
    t_g    = -1;
    if (m_phase == 0 && !i_rst && !cdc_busy)
      for (int i = 0; i < N; i++)
        if (t_g < 0 && t_elig[(m_last + 1 + i) % N]) t_g = (m_last + 1 + i) % N;
    if (t_g >= 0) t_rdy[t_g] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(t_rdy));
    chk("cdc_valid", 32'(cdc_valid), 32'(m_phase == 1));
    if (m_phase == 1) chk("cdc_data", 32'(cdc_data), 32'(m_hold));
    chk("o_grant_id", 32'(o_grant_id), 32'(m_gid));
    chk("o_xfer_cnt", 32'(o_xfer_cnt), 32'(m_cnt));
    chk("o_timeout", 32'(o_timeout), 32'(m_to));
    acc = req_ready;
    if (req_ready != '0) glog.push_back(oh2i(req_ready));
    if (i_rst) begin
      m_phase = 0; m_last = N - 1; m_gid = 0; m_cnt = 0; m_wait = 0; m_to = 0; m_hold = '0;
    end else begin
      case (m_phase)
        0: if (t_g >= 0) begin
             m_hold = {IW'(t_g), req_data[t_g*DW +: DW]};
             m_gid = t_g; m_last = t_g; m_phase = 1;
           end
        1: if (!cdc_busy) begin m_cnt = (m_cnt + 1) % (1 << CW); m_wait = 0; m_phase = 2; end
        default: begin
          if (m_wait == TO) m_to = 1'b1; else m_wait++;
          if (m_phase == 2 && cdc_busy) m_phase = 3;
          else if (m_phase == 3 && !cdc_busy) m_phase = 0;
        end
      endcase
    end
  end

  task automatic wait_grants(input int n, input int budget);
    int start, c;
    start = glog.size(); c = 0;
    while (glog.size() < start + n && c < budget) begin @(posedge i_clk); c++; end
    #1;
    checks++;
    if (glog.size() < start + n) begin
      fails++;
      $display("FAIL wait_grants: got %0d grants expected %0d", glog.size() - start, n);
    end
  endtask

  task automatic wait_idle(input int budget);
    int c;
    c = 0;
    while (!(m_phase == 0 && !cdc_busy) && c < budget) begin @(posedge i_clk); #1; c++; end
    checks++;
    if (c >= budget) begin fails++; $display("FAIL wait_idle: timed out after %0d cycles", c); end
  endtask

  task automatic pulse_reset();
    @(posedge i_clk); #1; i_rst = 1'b1;
    @(posedge i_clk); #1; i_rst = 1'b0;
  endtask

  typedef struct { logic [N-1:0] v; logic [N-1:0] m; int exp_id; int exp_cnt; } vec_t;
  vec_t tbl[10];

  initial begin
    int c, n0, busy_cyc;
    tbl[0] = '{4'b1111, 4'b1111, 3, 2};
    tbl[1] = '{4'b1111, 4'b1111, 0, 3};
    tbl[2] = '{4'b0011, 4'b1111, 1, 4};
    tbl[3] = '{4'b0001, 4'b1111, 0, 5};
    tbl[4] = '{4'b1111, 4'b1010, 1, 6};
    tbl[5] = '{4'b1111, 4'b1010, 3, 7};
    tbl[6] = '{4'b1100, 4'b0111, 2, 8};
    tbl[7] = '{4'b1001, 4'b1111, 3, 9};
    tbl[8] = '{4'b0110, 4'b1110, 1, 10};
    tbl[9] = '{4'b1111, 4'b0001, 0, 11};
    for (int k = 0; k < N; k++) req_data[k*DW +: DW] = DW'(8'h10 + k);
    req_data[2*DW +: DW] = 8'hA5;

    repeat (2) @(posedge i_clk);
    #1 chk_en = 1'b1;
    @(posedge i_clk); #1 i_rst = 1'b0;

    // Single word
    dly = 6;
    req_valid = 4'b0100;
    c = 0;
    do begin @(negedge i_clk); c++; end while (req_ready == '0 && c < 20);
    chk("single_ready", 32'(req_ready), 32'h4);
    @(posedge i_clk); #1 req_valid = '0;
    @(negedge i_clk);
    chk("single_valid_t1", 32'(cdc_valid), 32'h1);
    chk("single_data_t1", 32'(cdc_data), 32'h2A5);
    @(negedge i_clk);
    chk("single_busy_t2", 32'(cdc_busy), 32'h1);
    @(posedge i_clk); #1;
    wait_idle(50);
    chk("single_cnt", 32'(o_xfer_cnt), 32'd1);
    chk("single_gid", 32'(o_grant_id), 32'd2);

    // Table of single grants following the round-robin history
    dly = 3;
    for (int i = 0; i < 10; i++) begin
      req_valid = tbl[i].v; req_mask = tbl[i].m;
      wait_grants(1, 30);
      req_valid = '0;
      chk($sformatf("tbl%0d_id", i), 32'(glog[$]), 32'(tbl[i].exp_id));
      wait_idle(50);
      chk($sformatf("tbl%0d_cnt", i), 32'(o_xfer_cnt), 32'(tbl[i].exp_cnt));
    end

    // Fairness from reset
    pulse_reset();
    req_mask = 4'b1111; req_valid = 4'b1111;
    n0 = glog.size();
    wait_grants(8, 200);
    req_valid = '0;
    for (int i = 0; i < 8; i++) chk($sformatf("fair%0d", i), 32'(glog[n0 + i]), 32'(i % 4));
    wait_idle(50);
    chk("fair_cnt", 32'(o_xfer_cnt), 32'd8);

    // Masking
    req_mask = 4'b1010; req_valid = 4'b1111;
    n0 = glog.size();
    wait_grants(4, 120);
    req_valid = '0;
    for (int i = 0; i < 4; i++) chk($sformatf("mask%0d", i), 32'(glog[n0 + i]), (i % 2) ? 32'd3 : 32'd1);
    wait_idle(50);
    req_mask = 4'b1111;

    // Stall: timeout after TO+1 wait cycles, sticky, no grant while waiting
    dly = 2000;
    req_valid = 4'b0001;
    wait_grants(1, 20);
    chk("stall_id", 32'(glog[$]), 32'd0);
    req_valid = 4'b0010;
    n0 = glog.size();
    c = 0;
    do begin @(negedge i_clk); c++; end while (!(cdc_valid && !cdc_busy) && c < 20);
    repeat (TO + 1) @(negedge i_clk);
    chk("stall_to_before", 32'(o_timeout), 32'd0);
    @(negedge i_clk);
    chk("stall_to_rise", 32'(o_timeout), 32'd1);
    @(posedge i_clk); #1;
    wait_idle(2500);
    chk("stall_no_grant", 32'(glog.size()), 32'(n0));
    chk("stall_cnt", 32'(o_xfer_cnt), 32'd13);
    dly = 3;
    wait_grants(1, 20);
    req_valid = '0;
    chk("stall_next_id", 32'(glog[$]), 32'd1);
    wait_idle(50);
    chk("stall_to_sticky", 32'(o_timeout), 32'd1);

    // Reset in WAIT_LO, then busy at IDLE
    dly = 6;
    req_valid = 4'b0100;
    wait_grants(1, 20);
    req_valid = 4'b0001;
    c = 0;
    do begin @(negedge i_clk); c++; end while (!(cdc_valid && !cdc_busy) && c < 20);
    @(posedge i_clk); #1;
    @(posedge i_clk); #1 i_rst = 1'b1;
    @(posedge i_clk); #1 i_rst = 1'b0;
    @(negedge i_clk);
    chk("rst_valid", 32'(cdc_valid), 32'd0);
    chk("rst_data", 32'(cdc_data), 32'd0);
    chk("rst_gid", 32'(o_grant_id), 32'd0);
    chk("rst_cnt", 32'(o_xfer_cnt), 32'd0);
    chk("rst_to", 32'(o_timeout), 32'd0);
    chk("rst_busy_held", 32'(cdc_busy), 32'd1);
    busy_cyc = 0; c = 0;
    while (cdc_busy && c < 20) begin
      if (req_ready != '0) busy_cyc++;
      @(negedge i_clk); c++;
    end
    chk("busy_idle_noready", 32'(busy_cyc), 32'd0);
    chk("busy_idle_grant", 32'(req_ready), 32'h1);
    @(posedge i_clk); #1 req_valid = '0;
    wait_idle(50);
    chk("wrap_cnt1", 32'(o_xfer_cnt), 32'd1);

    // Wrap: 16 more words on a 4-bit counter
    dly = 2;
    req_valid = 4'b1111;
    wait_grants(16, 400);
    req_valid = '0;
    wait_idle(50);
    chk("wrap_cnt17", 32'(o_xfer_cnt), 32'd1);

    // Random traffic against the model
    for (int cy = 0; cy < 3000; cy++) begin
      @(posedge i_clk); #1;
      dly = $urandom_range(1, 6);
      if ($urandom_range(0, 15) == 0) req_mask = N'($urandom);
      for (int k = 0; k < N; k++) begin
        if (acc[k]) req_valid[k] = 1'b0;
        else if (req_valid[k] && $urandom_range(0, 99) == 0) req_valid[k] = 1'b0;
        if (!req_valid[k] && $urandom_range(0, 3) == 0) begin
          req_valid[k] = 1'b1;
          req_data[k*DW +: DW] = DW'($urandom);
        end
      end
    end
    req_valid = '0;
    wait_idle(50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
